// File: rtl/onehot_dec_pkg.sv
// Shared types and the index-to-one-hot rule for the registered one-hot decoder.
package onehot_dec_pkg;

    localparam int DEC_MAX_W = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // Indices at or beyond the active width decode to all zeros.
    function automatic logic [DEC_MAX_W-1:0] decode(input int unsigned index,
                                                    input int unsigned width);
        logic [DEC_MAX_W-1:0] vec;
        vec = '0;
        if (index < width) begin
            vec = DEC_MAX_W'(1) << index;
        end
        return vec;
    endfunction

endpackage

// File: rtl/onehot_dec_skid.sv
// Generic 2-entry valid/ready skid buffer: an output register plus one spill slot,
// with s_ready registered from the next occupancy so it never sees m_ready combinationally.
module onehot_dec_skid
    import onehot_dec_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    skid_state_e       state_q, state_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              ready_q;
    logic              inFire;

    assign inFire  = s_valid && ready_q;
    assign s_ready = ready_q;
    assign m_valid = (state_q != EMPTY);
    assign m_data  = out_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (inFire) begin
                    out_d   = s_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (inFire && m_ready) begin
                    out_d = s_data;
                end else if (inFire) begin
                    skid_d  = s_data;
                    state_d = FULL;
                end else if (m_ready) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (m_ready) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // ready_q stays low through reset so nothing is accepted until the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            ready_q <= (state_d != FULL);
        end
    end

endmodule

// File: rtl/onehot_decoder_reg.sv
// Binary index to one-hot decoder with a registered valid/ready output stream.
// Define ONEHOT_DEC_RANGE_CHECK_EN to drop out-of-range indices and pulse err instead.
module onehot_decoder_reg
    import onehot_dec_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] s_index,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_onehot,
    output logic [IDX_W-1:0] m_index,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             err
);

    localparam int DATA_W = IDX_W + WIDTH;

    logic [WIDTH-1:0]  decOnehot;
    logic              skidValid;
    logic              skidReady;
    logic [DATA_W-1:0] skidOut;

    assign decOnehot = WIDTH'(decode(32'(s_index), 32'(WIDTH)));

`ifdef ONEHOT_DEC_RANGE_CHECK_EN
    logic inRange;
    logic err_q, err_d;

    // Out-of-range beats are still handshaken so the source never stalls on them.
    assign inRange   = 32'(s_index) < 32'(WIDTH);
    assign skidValid = s_valid && inRange;
    assign err_d     = s_valid && skidReady && !inRange;
    assign err       = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign skidValid = s_valid;
    assign err       = 1'b0;
`endif

    assign s_ready = skidReady;

    onehot_dec_skid #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .s_data ({s_index, decOnehot}),
        .s_valid(skidValid),
        .s_ready(skidReady),
        .m_data (skidOut),
        .m_valid(m_valid),
        .m_ready(m_ready)
    );

    assign m_onehot = skidOut[WIDTH-1:0];
    assign m_index  = skidOut[DATA_W-1:WIDTH];

endmodule
